// File: rtl/secuenciador_avance_pkg.sv
// Shared definitions for the advance sequencer: step encoding, widths and
// default credit parameters.
package secuenciador_pkg;

  localparam int ESTADO_W = 3;
  localparam logic [ESTADO_W-1:0] ULTIMO_ESTADO = 3'd5;

  localparam int CREDIT_W_DEF   = 4;
  localparam int CREDIT_MAX_DEF = 15;

  typedef enum logic [ESTADO_W-1:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } paso_t;

  // Step sequence wraps after the last step; 6 and 7 are never produced.
  function automatic paso_t siguiente_paso(input paso_t p);
    paso_t sig;
    if (p >= paso_t'(ULTIMO_ESTADO)) begin
      sig = S0;
    end else begin
      sig = paso_t'(p + 3'd1);
    end
    return sig;
  endfunction

endpackage

// File: rtl/secuenciador_avance_if.sv
// Raw coin/button inputs and the clean status outputs of the sequencer.
interface secuenciador_avance_if
  import secuenciador_pkg::*;
#(
  parameter int CREDIT_W = CREDIT_W_DEF
);

  logic                moneda;
  logic                boton;
  logic [ESTADO_W-1:0] estado;
  logic                avance;
  logic                credito;
  logic [CREDIT_W-1:0] credito_cnt;
  logic                rechazo;
  logic                lleno;

  modport master (
    output moneda,
    output boton,
    input  estado,
    input  avance,
    input  credito,
    input  credito_cnt,
    input  rechazo,
    input  lleno
  );

  modport slave (
    input  moneda,
    input  boton,
    output estado,
    output avance,
    output credito,
    output credito_cnt,
    output rechazo,
    output lleno
  );

endinterface

// File: rtl/secuenciador_avance_antirrebote.sv
// Synchroniser, debounce filter and rising-edge event for one raw contact.
module antirrebote #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_evento
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_nivel;
  logic             r_nivel_d;
  logic             r_evento;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_nivel   <= 1'b0;
      r_nivel_d <= 1'b0;
      r_evento  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_nivel_d <= r_nivel;
      r_evento  <= r_nivel & ~r_nivel_d;
      // Any cycle agreeing with the accepted level restarts the run.
      if (r_sync2 == r_nivel) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_ULTIMO) begin
        r_nivel <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_evento = r_evento;

endmodule

// File: rtl/secuenciador_avance.sv
// Coin/advance sequencer: debounced events drive a saturating credit counter
// and a six-step sequence, with every output registered.
//
// state | meaning
// S0    | step 0, idle / start of sequence
// S1    | step 1
// S2    | step 2
// S3    | step 3
// S4    | step 4
// S5    | step 5, next advance wraps to S0 and consumes one credit
module secuenciador_avance
  import secuenciador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CREDIT_W        = CREDIT_W_DEF,
  parameter int CREDIT_MAX      = CREDIT_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  secuenciador_avance_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] CNT_MAX = CREDIT_W'(CREDIT_MAX);

  logic w_ev_moneda;
  logic w_ev_boton;
  logic w_wrap;
  logic [CREDIT_W-1:0] w_cnt_next;

  paso_t               r_paso;
  logic [CREDIT_W-1:0] r_cnt;
  logic                r_credito;
  logic                r_avance;
  logic                r_rechazo;
  logic                r_lleno;
  logic                r_inc;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ar_moneda (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (bus.moneda),
    .o_evento (w_ev_moneda)
  );

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_ar_boton (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (bus.boton),
    .o_evento (w_ev_boton)
  );

  // Accepted coin and wrap land on the same edge, so they cancel out.
  assign w_wrap = r_avance && (r_paso == S5);

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_inc && !w_wrap) begin
      w_cnt_next = r_cnt + CREDIT_W'(1);
    end else if (!r_inc && w_wrap) begin
      w_cnt_next = r_cnt - CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_paso    <= S0;
      r_cnt     <= '0;
      r_credito <= 1'b0;
      r_avance  <= 1'b0;
      r_rechazo <= 1'b0;
      r_lleno   <= 1'b0;
      r_inc     <= 1'b0;
    end else begin
      // Both events are judged on the count as registered, before any
      // coin increment from this same cycle has been applied.
      r_avance  <= w_ev_boton && (r_cnt != '0);
      r_rechazo <= w_ev_boton && (r_cnt == '0);
      r_inc     <= w_ev_moneda && (r_cnt < CNT_MAX);
      r_lleno   <= w_ev_moneda && (r_cnt >= CNT_MAX);
      r_cnt     <= w_cnt_next;
      r_credito <= (w_cnt_next != '0);
      if (r_avance) begin
        r_paso <= siguiente_paso(r_paso);
      end
    end
  end

  assign bus.estado      = r_paso;
  assign bus.avance      = r_avance;
  assign bus.credito     = r_credito;
  assign bus.credito_cnt = r_cnt;
  assign bus.rechazo     = r_rechazo;
  assign bus.lleno       = r_lleno;

endmodule
